sclk_gen: RTL and testbench
===========================

# sclk_gen

Parametrised serial-clock burst generator for the converter interfaces (DAC/ADC shift-register links feeding the FIR/IIR datapath). It generates an SCLK of programmable frequency and idle polarity from the system clock, and runs a counted burst of SCLK cycles per start request. It also supplies one-cycle leading- and trailing-edge strobes so that shift registers stay in the single `clk` domain. It replaces fixed-ratio SCLK dividers.

## Interface
- `DIV_W`, default 8: width of the half-period divisor.
- `CNT_W`, default 6: width of the burst length in SCLK cycles.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  block enable; low means synchronous abort and hold idle.
- `start`  in  1  one-cycle burst request.
- `div`  in  DIV_W  SCLK half-period minus 1, in `clk` cycles.
- `cpol`  in  1  SCLK idle level.
- `nbits`  in  CNT_W  SCLK cycles per burst.
- `busy`  out  1  burst in progress.
- `done`  out  1  one-cycle pulse when a burst completes normally.
- `SCLK`  out  1  generated serial clock (registered).
- `lead_stb`  out  1  one-cycle pulse; SCLK just left its idle level.
- `trail_stb`  out  1  one-cycle pulse; SCLK just returned to its idle level.

## Operation
- States: IDLE, RUN.
- IDLE:
  - `SCLK` equals the registered `cpol`, with one cycle of lag.
  - Strobes are 0.
  - `start` with `en`=1 latches `div`, `cpol`, `nbits` into `div_l`, `cpol_l`, `nbits_l`, clears the counters and enters RUN.
- `nbits`=0 on start: no RUN phase, no SCLK edges; `done` pulses for one cycle and `busy` stays 0.
- RUN:
  - `busy`=1.
  - The half-period counter `hcnt` counts 0..`div_l`.
  - When `hcnt`==`div_l`: `SCLK` toggles and `hcnt` returns to 0.
  - A toggle away from `cpol_l` asserts `lead_stb`.
  - A toggle back to `cpol_l` asserts `trail_stb` and increments the trailing-edge counter `ecnt`.
- Completion: on the trailing edge that makes `ecnt`==`nbits_l`, go to IDLE. In that same cycle `trail_stb`=1, `done`=1 and `busy`=0.
- Input changes:
  - `start` while in RUN is ignored.
  - `start` with `en`=0 is ignored.
  - Changes on `div`, `cpol` or `nbits` during RUN have no effect until the next start.
- `en`=0 in any state:
  - Next cycle: IDLE, `SCLK`=`cpol_l`, `busy`=0, strobes 0.
  - No `done` pulse.
  - Counters are cleared.
- Arithmetic and frequency:
  - SCLK frequency is f_clk / (2·(`div`+1)).
  - `div`=0 gives f_clk/2; `div`=1 gives f_clk/4.
  - `hcnt` is DIV_W bits and `ecnt` is CNT_W bits; no wrap is possible because the compares are exact.
  - Maximum burst is 2^CNT_W − 1 cycles.
- Reset (`rst`=0, asynchronous):
  - IDLE; `SCLK`=0, `busy`=0, `done`=0, `lead_stb`=0, `trail_stb`=0.
  - `cpol_l`=0, counters 0.
  - Applies immediately, including in the middle of a burst.

## Timing
- All outputs are registered, with no combinational paths from inputs.
- Let `start` be sampled at edge T0.
  - `busy`=1 from T0.
  - First SCLK toggle (leading edge) at T0+(`div`+1).
  - Edge k (1-based) occurs at T0+k·(`div`+1).
  - Final trailing edge, with `done`, occurs at T0+2·`nbits`·(`div`+1).
- Strobes:
  - Strobes are high during the cycle in which `SCLK` already shows its new value.
  - `lead_stb` and `trail_stb` are never asserted together.
- Back-to-back bursts: `start` in the `done` cycle is accepted, because the state is already IDLE at that edge. The new burst's first edge follows by `div`+1 cycles.
- `nbits`=0: `done` is high at T0+1.
- Abort: `en` low sampled at edge Ta gives the idle state from Ta.

## Structure
- Package `sclk_pkg`:
  - typedef `sclk_state_t` {IDLE, RUN}.
  - Default constants for `DIV_W` and `CNT_W`.
- Single module, no sub-modules: the counters and FSM stay inline (≈150 lines).

## Test plan
- `div`=1, `cpol`=0, `nbits`=4, start at T0:
  - SCLK period 4 clk.
  - 4 `lead_stb` and 4 `trail_stb` pulses.
  - `done` and `busy`↓ at T0+16; SCLK=0 afterwards.
- `div`=0, `cpol`=1, `nbits`=1:
  - Idle level high.
  - SCLK falls at T0+1 with `lead_stb` and rises at T0+2 with `trail_stb` and `done`.
- `div`=2, `nbits`=8, `en` dropped after the 3rd trailing edge:
  - SCLK=`cpol` and `busy`=0 on the next cycle.
  - No `done` pulse.
  - A subsequent start runs a full 8-cycle burst.
- Start during RUN is ignored and burst length is unchanged. `nbits`=0 gives a single `done` at T0+1, no SCLK edges, and `busy` never high.
- `rst` asserted at T0+5 of a `div`=1, `nbits`=4 burst:
  - All outputs 0 immediately.
  - After release, IDLE; start works normally.
- `div`=255, `nbits`=63, `cpol`=0:
  - Exactly 63 trailing edges.
  - `done` at T0+32256.
  - Changes on `div` or `cpol` mid-burst have no effect.

Source files
------------

// File: rtl/sclk_pkg.sv
// Shared types and default widths for the serial-clock burst generator.
package sclk_pkg;

  localparam int unsigned SCLK_DIV_W = 8;
  localparam int unsigned SCLK_CNT_W = 6;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sclk_state_t;

endpackage

// File: rtl/sclk_gen.sv
// Counted-burst SCLK generator with registered outputs and single-cycle edge strobes.
module sclk_gen
  import sclk_pkg::*;
#(
  parameter int unsigned DIV_W = SCLK_DIV_W,
  parameter int unsigned CNT_W = SCLK_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [DIV_W-1:0] div,
  input  logic             cpol,
  input  logic [CNT_W-1:0] nbits,
  output logic             busy,
  output logic             done,
  output logic             SCLK,
  output logic             lead_stb,
  output logic             trail_stb
);

  sclk_state_t      state_q, state_d;
  logic [DIV_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;
  logic [DIV_W-1:0] div_l_q, div_l_d;
  logic             cpol_l_q, cpol_l_d;
  logic [CNT_W-1:0] nbits_l_q, nbits_l_d;
  logic             sclk_q, sclk_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             lead_q, lead_d;
  logic             trail_q, trail_d;
  logic             zpend_q, zpend_d;
  logic [CNT_W-1:0] ecnt_inc;

  assign ecnt_inc = ecnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    ecnt_d    = ecnt_q;
    div_l_d   = div_l_q;
    cpol_l_d  = cpol_l_q;
    nbits_l_d = nbits_l_q;
    sclk_d    = sclk_q;
    done_d    = 1'b0;
    lead_d    = 1'b0;
    trail_d   = 1'b0;
    zpend_d   = 1'b0;

    if (!en) begin
      // Abort: drop straight to idle level, no done, counters cleared.
      state_d  = IDLE;
      hcnt_d   = '0;
      ecnt_d   = '0;
      sclk_d   = cpol_l_q;
      cpol_l_d = (state_q == IDLE) ? cpol : cpol_l_q;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_d   = zpend_q;
          sclk_d   = cpol_l_q;
          cpol_l_d = cpol;
          if (start) begin
            div_l_d   = div;
            nbits_l_d = nbits;
            hcnt_d    = '0;
            ecnt_d    = '0;
            if (nbits == '0) begin
              // Zero-length burst: done follows one cycle later, never busy.
              zpend_d = 1'b1;
            end else begin
              state_d = RUN;
              sclk_d  = cpol;
            end
          end
        end
        RUN: begin
          if (hcnt_q == div_l_q) begin
            hcnt_d = '0;
            sclk_d = ~sclk_q;
            if (sclk_q == cpol_l_q) begin
              lead_d = 1'b1;
            end else begin
              trail_d = 1'b1;
              ecnt_d  = ecnt_inc;
              if (ecnt_inc == nbits_l_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end
          end else begin
            hcnt_d = hcnt_q + DIV_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      hcnt_q    <= '0;
      ecnt_q    <= '0;
      div_l_q   <= '0;
      cpol_l_q  <= 1'b0;
      nbits_l_q <= '0;
      sclk_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      lead_q    <= 1'b0;
      trail_q   <= 1'b0;
      zpend_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      ecnt_q    <= ecnt_d;
      div_l_q   <= div_l_d;
      cpol_l_q  <= cpol_l_d;
      nbits_l_q <= nbits_l_d;
      sclk_q    <= sclk_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      lead_q    <= lead_d;
      trail_q   <= trail_d;
      zpend_q   <= zpend_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign SCLK      = sclk_q;
  assign lead_stb  = lead_q;
  assign trail_stb = trail_q;

endmodule

// File: tb/tb_sclk_gen.sv
// Scoreboard bench for sclk_gen: expected strobe/done events are queued at start, checked as seen.
module tb_sclk_gen;

  typedef struct {
    int         at;
    logic [2:0] kind;  // {done, trail_stb, lead_stb}
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic       start = 1'b0;
  logic [7:0] div = '0;
  logic       cpol = 1'b0;
  logic [5:0] nbits = '0;
  logic       busy, done, SCLK, lead_stb, trail_stb;

  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  ev_t exp_q[$];

  sclk_gen #(
    .DIV_W(8),
    .CNT_W(6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .start    (start),
    .div      (div),
    .cpol     (cpol),
    .nbits    (nbits),
    .busy     (busy),
    .done     (done),
    .SCLK     (SCLK),
    .lead_stb (lead_stb),
    .trail_stb(trail_stb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: every strobe/done pulse must match the head of the scoreboard.
  initial begin
    ev_t        e;
    logic [2:0] obs;
    forever begin
      @(negedge clk);
      if (rst) begin
        obs = {done, trail_stb, lead_stb};
        if (obs != 3'b000) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event cyc=%0d got=%b want=none", cyc, obs);
          end else begin
            e = exp_q.pop_front();
            if (e.at != cyc || e.kind !== obs) begin
              bad++;
              $display("FAIL event cyc=%0d got=%b want cyc=%0d kind=%b", cyc, obs, e.at, e.kind);
            end
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1);
  end

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Issue a start from a negedge; t0 is the edge that samples it.
  task automatic go(input int d, input bit p, input int n, output int t0);
    @(negedge clk);
    div   = 8'(d);
    cpol  = p;
    nbits = 6'(n);
    start = 1'b1;
    t0    = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_burst(input int t0, input int d, input int n, input int kmax);
    for (int k = 1; k <= kmax; k++) begin
      ev_t e;
      e.at   = t0 + k * (d + 1);
      e.kind = (k % 2 == 1) ? 3'b001 : ((k == 2 * n) ? 3'b110 : 3'b010);
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({busy, done, SCLK, lead_stb, trail_stb} !== 5'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=00000", {busy, done, SCLK, lead_stb, trail_stb});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (SCLK !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset got sclk=%b busy=%b want 0 0", SCLK, busy);
    end
  endtask

  task automatic test_basic_burst();
    int t0;
    go(1, 1'b0, 4, t0);
    push_burst(t0, 1, 4, 8);
    wait_until(t0);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_at_t0 got=%b want=1", busy);
    end
    wait_until(t0 + 1);
    total++;
    if (SCLK !== 1'b0) begin bad++; $display("FAIL sclk_t0p1 got=%b want=0", SCLK); end
    wait_until(t0 + 2);
    total++;
    if (SCLK !== 1'b1) begin bad++; $display("FAIL sclk_t0p2 got=%b want=1", SCLK); end
    wait_until(t0 + 4);
    total++;
    if (SCLK !== 1'b0) begin bad++; $display("FAIL sclk_t0p4 got=%b want=0", SCLK); end
    wait_until(t0 + 15);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_t0p15 got=%b want=1", busy); end
    wait_until(t0 + 16);
    total++;
    if (busy !== 1'b0 || SCLK !== 1'b0) begin
      bad++;
      $display("FAIL end_t0p16 got busy=%b sclk=%b want 0 0", busy, SCLK);
    end
    wait_until(t0 + 18);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL basic_pending got=%0d want=0", exp_q.size());
    end
  endtask

  task automatic test_cpol_high();
    int t0;
    @(negedge clk);
    cpol = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (SCLK !== 1'b1) begin bad++; $display("FAIL idle_cpol1 got=%b want=1", SCLK); end
    go(0, 1'b1, 1, t0);
    push_burst(t0, 0, 1, 2);
    wait_until(t0 + 1);
    total++;
    if (SCLK !== 1'b0) begin bad++; $display("FAIL cpol1_fall got=%b want=0", SCLK); end
    wait_until(t0 + 2);
    total++;
    if (SCLK !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL cpol1_rise got sclk=%b busy=%b want 1 0", SCLK, busy);
    end
    wait_until(t0 + 4);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL cpol1_pending got=%0d want=0", exp_q.size()); end
    cpol = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_abort();
    int t0;
    int t1;
    go(2, 1'b0, 8, t0);
    push_burst(t0, 2, 8, 7);
    wait_until(t0 + 21);
    total++;
    if (SCLK !== 1'b1) begin bad++; $display("FAIL abort_pre_sclk got=%b want=1", SCLK); end
    en = 1'b0;
    wait_until(t0 + 22);
    total++;
    if (SCLK !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle got sclk=%b busy=%b want 0 0", SCLK, busy);
    end
    repeat (40) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL abort_pending got=%0d want=0", exp_q.size()); end
    en = 1'b1;
    go(2, 1'b0, 8, t1);
    push_burst(t1, 2, 8, 16);
    wait_until(t1 + 48);
    total++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL abort_rerun got busy=%b pending=%0d want 0 0", busy, exp_q.size());
    end
  endtask

  task automatic test_start_ignored_and_zero();
    int  t0;
    ev_t e;
    go(0, 1'b0, 3, t0);
    push_burst(t0, 0, 3, 6);
    wait_until(t0 + 2);
    div   = 8'd2;
    nbits = 6'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(t0 + 6);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL run_start_busy got=%b want=0", busy); end
    wait_until(t0 + 12);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL run_start_pending got=%0d want=0", exp_q.size()); end
    go(3, 1'b0, 0, t0);
    e.at   = t0 + 1;
    e.kind = 3'b100;
    exp_q.push_back(e);
    for (int i = 0; i < 10; i++) begin
      wait_until(t0 + i);
      total++;
      if (busy !== 1'b0 || SCLK !== 1'b0) begin
        bad++;
        $display("FAIL zero_len cyc=%0d got busy=%b sclk=%b want 0 0", cyc, busy, SCLK);
      end
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL zero_pending got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int t0;
    int t1;
    go(0, 1'b0, 2, t0);
    push_burst(t0, 0, 2, 4);
    wait_until(t0 + 4);
    div   = 8'd1;
    nbits = 6'd1;
    start = 1'b1;
    t1    = cyc + 1;
    push_burst(t1, 1, 1, 2);
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b want=1", busy); end
    wait_until(t1 + 6);
    total++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_end got busy=%b pending=%0d want 0 0", busy, exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    int t0;
    go(1, 1'b0, 4, t0);
    push_burst(t0, 1, 4, 3);
    wait_until(t0 + 6);
    #2;
    rst = 1'b0;
    #1;
    total++;
    if ({busy, done, SCLK, lead_stb, trail_stb} !== 5'b0) begin
      bad++;
      $display("FAIL async_reset got=%b want=00000", {busy, done, SCLK, lead_stb, trail_stb});
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    total++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL post_reset got pending=%0d busy=%b want 0 0", exp_q.size(), busy);
    end
    go(1, 1'b0, 2, t0);
    push_burst(t0, 1, 2, 4);
    wait_until(t0 + 9);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL reset_rerun got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_long_burst();
    int t0;
    go(255, 1'b0, 63, t0);
    push_burst(t0, 255, 63, 126);
    wait_until(t0 + 100);
    div   = 8'd3;
    cpol  = 1'b1;
    nbits = 6'd2;
    wait_until(t0 + 32255);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL long_busy got=%b want=1", busy); end
    wait_until(t0 + 32256);
    total++;
    if (busy !== 1'b0 || SCLK !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL long_end got busy=%b sclk=%b pending=%0d want 0 0 0", busy, SCLK,
               exp_q.size());
    end
    cpol = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_cpol_high();
    test_abort();
    test_start_ignored_and_zero();
    test_back_to_back();
    test_async_reset();
    test_long_burst();
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
